// File: rtl/nest_placer.sv
// -----------------------------------------------------------------------------
// nest_placer
//
// Setup-phase placement controller sitting in front of the nest object. A
// cursor is steered with four direction keys (single step on each press,
// auto-repeat while held). On a key_place press the candidate site is checked
// against the obstacle collision result; a clear site produces a one-cycle SET
// strobe that loads the nest position, a blocked site produces a one-cycle
// reject pulse. Nothing moves or fires while SETUP_PHASE is low.
//
// Optional feature macro: NEST_PLACER_WRAP_EN
//   defined   -> cursor motion wraps between the legal bounds
//   undefined -> cursor motion clamps at the legal bounds
//
// Ports
//   setup_clk    clock
//   RESET        asynchronous active-high reset
//   SETUP_PHASE  high while the world is being configured
//   key_up/down/left/right  synchronised direction key levels
//                           (up decreases Y, right increases X)
//   key_place    placement request level (rising edge acts)
//   blocked      collision result for the current cursor, settles CHECK_LAT
//                cycles after a cursor change
//   cursor_x/y   candidate position (nest in_x/in_y, obstacle collide_x/y)
//   SET          one-cycle nest load strobe, only while SETUP_PHASE=1
//   placed       nest committed during this setup phase
//   reject       one-cycle pulse when a placement is refused
// -----------------------------------------------------------------------------
module nest_placer #(
    parameter int X_bits       = 10,
    parameter int Y_bits       = 9,
    parameter int X_MAX        = 639,
    parameter int Y_MAX        = 479,
    parameter int NEST_RADIUS  = 8,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4,
    parameter int CHECK_LAT    = 2
) (
    input  logic              setup_clk,
    input  logic              RESET,
    input  logic              SETUP_PHASE,
    input  logic              key_up,
    input  logic              key_down,
    input  logic              key_left,
    input  logic              key_right,
    input  logic              key_place,
    input  logic              blocked,
    output logic [X_bits-1:0] cursor_x,
    output logic [Y_bits-1:0] cursor_y,
    output logic              SET,
    output logic              placed,
    output logic              reject
);

    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
    localparam int STL_W = (CHECK_LAT > 0) ? $clog2(CHECK_LAT + 1) : 1;
    localparam int X_LO  = NEST_RADIUS;
    localparam int X_HI  = X_MAX - NEST_RADIUS;
    localparam int Y_LO  = NEST_RADIUS;
    localparam int Y_HI  = Y_MAX - NEST_RADIUS;

    typedef enum logic [2:0] {
        IDLE,
        AIM,
        CHECK,
        COMMIT,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [X_bits-1:0] cx_q, cx_d;
    logic [Y_bits-1:0] cy_q, cy_d;
    logic [3:0]        held_q;
    logic              place_q;
    logic [RPT_W-1:0]  rpt_q, rpt_d;
    logic [STL_W-1:0]  settle_q, settle_d;
    logic              placed_q, placed_d;
    logic              reject_q, reject_d;

    logic [3:0] held;
    logic [3:0] key_rise;
    logic [3:0] step;
    logic       place_edge;
    logic       in_aim;
    logic       set_chg;
    logic       rpt_hit;
    logic       move_en;

    // One-unit move along an axis followed by bound handling. inc and dec are
    // never both set by the caller (opposite keys cancel before this point).
    function automatic int axis_step(input int pos, input logic inc, input logic dec,
                                     input int lo, input int hi);
        int nxt;
        nxt = pos;
        if (inc) nxt = pos + 1;
        else if (dec) nxt = pos - 1;
`ifdef NEST_PLACER_WRAP_EN
        if (nxt > hi) nxt = lo;
        else if (nxt < lo) nxt = hi;
`else
        if (nxt > hi) nxt = hi;
        else if (nxt < lo) nxt = lo;
`endif
        return nxt;
    endfunction

    // Key order in every 4-bit vector: {up, down, left, right}
    assign held       = {key_up, key_down, key_left, key_right};
    assign key_rise   = held & ~held_q;
    assign place_edge = key_place & ~place_q;
    assign in_aim     = SETUP_PHASE && (state_q == AIM);
    assign set_chg    = (held != held_q);
    // rpt_q counts cycles since the held set last changed; reaching
    // REPEAT_DELAY fires a repeat and reloads so the next hit is REPEAT_RATE on.
    assign rpt_hit    = !set_chg && (held != 4'b0000) && (rpt_q == RPT_W'(REPEAT_DELAY));
    assign step       = key_rise | (rpt_hit ? held : 4'b0000);
    // The key_place edge cycle already belongs to the check; no motion then.
    assign move_en    = in_aim && !place_edge;

    // ---- next-state / outputs ----
    always_comb begin
        state_d = state_q;
        if (!SETUP_PHASE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = AIM;
                AIM:     if (place_edge) state_d = CHECK;
                CHECK:   if (settle_q == '0) state_d = blocked ? AIM : COMMIT;
                COMMIT:  state_d = DONE;
                DONE:    if (place_edge) state_d = AIM;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (move_en) begin
            cx_d = X_bits'(axis_step(int'(cx_q), step[0] && !key_left,
                                     step[1] && !key_right, X_LO, X_HI));
            cy_d = Y_bits'(axis_step(int'(cy_q), step[2] && !key_up,
                                     step[3] && !key_down, Y_LO, Y_HI));
        end

        if (!in_aim || (held == 4'b0000)) rpt_d = '0;
        else if (set_chg)                 rpt_d = RPT_W'(1);
        else if (rpt_hit)                 rpt_d = RPT_W'(REPEAT_DELAY - REPEAT_RATE + 1);
        else                              rpt_d = rpt_q + 1'b1;

        if ((cx_d != cx_q) || (cy_d != cy_q)) settle_d = STL_W'(CHECK_LAT);
        else if (settle_q != '0)              settle_d = settle_q - 1'b1;
        else                                  settle_d = settle_q;

        reject_d = SETUP_PHASE && (state_q == CHECK) && (settle_q == '0) && blocked;

        placed_d = placed_q;
        if (SETUP_PHASE) begin
            if (state_q == COMMIT) placed_d = 1'b1;
            else if ((state_q == IDLE) || ((state_q == DONE) && place_edge)) placed_d = 1'b0;
        end
    end

    // ---- state register ----
    always_ff @(posedge setup_clk or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---- cursor, detectors and counters ----
    always_ff @(posedge setup_clk or posedge RESET) begin
        if (RESET) begin
            cx_q     <= X_bits'(X_MAX / 2);
            cy_q     <= Y_bits'(Y_MAX / 2);
            held_q   <= 4'b0000;
            place_q  <= 1'b0;
            rpt_q    <= '0;
            settle_q <= '0;
            placed_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            held_q   <= held;
            place_q  <= key_place;
            rpt_q    <= rpt_d;
            settle_q <= settle_d;
            placed_q <= placed_d;
            reject_q <= reject_d;
        end
    end

    // SET decodes straight from the state so a falling SETUP_PHASE kills it
    // in the same cycle.
    assign SET      = (state_q == COMMIT) && SETUP_PHASE;
    assign cursor_x = cx_q;
    assign cursor_y = cy_q;
    assign placed   = placed_q;
    assign reject   = reject_q;

endmodule

// File: tb/tb_nest_placer.sv
module tb_nest_placer;

    localparam int XB = 10, YB = 9, XMAX = 639, YMAX = 479, NR = 8;
    localparam int RD = 16, RR = 4, LAT = 2;
    localparam int M_IDLE = 0, M_AIM = 1, M_CHECK = 2, M_COMMIT = 3, M_DONE = 4;
    localparam int KU = 0, KD = 1, KL = 2, KR = 3, KP = 4;

    logic setup_clk = 1'b0;
    logic RESET = 1'b1;
    logic SETUP_PHASE = 1'b0;
    logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
    logic key_place = 1'b0, blocked = 1'b0;
    logic [XB-1:0] cursor_x;
    logic [YB-1:0] cursor_y;
    logic SET, placed, reject;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int       m_mode, m_x, m_y, m_age, m_k;
    bit       m_placed, m_rej, m_was_aim, m_pplace;
    logic [3:0] m_pheld;

    nest_placer #(
        .X_bits(XB), .Y_bits(YB), .X_MAX(XMAX), .Y_MAX(YMAX), .NEST_RADIUS(NR),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CHECK_LAT(LAT)
    ) dut (
        .setup_clk(setup_clk), .RESET(RESET), .SETUP_PHASE(SETUP_PHASE),
        .key_up(key_up), .key_down(key_down), .key_left(key_left),
        .key_right(key_right), .key_place(key_place), .blocked(blocked),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .SET(SET),
        .placed(placed), .reject(reject)
    );

    always #5 setup_clk = ~setup_clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Position after moving by d (-1, 0, +1) inside [lo, hi].
    function automatic int mv(input int p, input int d, input int lo, input int hi);
        int n;
`ifdef NEST_PLACER_WRAP_EN
        int span;
        span = hi - lo + 1;
        n = p + d;
        return lo + ((((n - lo) % span) + span) % span);
`else
        n = p + d;
        return (n < lo) ? lo : ((n > hi) ? hi : n);
`endif
    endfunction

    task m_reset();
        m_mode = M_IDLE; m_x = XMAX / 2; m_y = YMAX / 2; m_age = LAT; m_k = 0;
        m_placed = 0; m_rej = 0; m_was_aim = 0; m_pplace = 0; m_pheld = 4'b0000;
    endtask

    // Behavioural model: advances once per rising clock from the applied inputs.
    initial begin : model
        logic [3:0] hv, sv;
        bit pe, chg, in_aim, rep, rj;
        int dx, dy, nx, ny, nmode;
        m_reset();
        forever begin
            @(posedge setup_clk);
            if (RESET) begin
                m_reset();
            end else begin
                hv     = {key_up, key_down, key_left, key_right};
                pe     = key_place && !m_pplace;
                chg    = (hv != m_pheld);
                in_aim = SETUP_PHASE && (m_mode == M_AIM);
                // k = cycles the current held set has been held inside this AIM run
                if (in_aim) m_k = (chg || !m_was_aim) ? 0 : m_k + 1;
                rep = in_aim && !chg && (hv != 4'b0000) && (m_k >= RD) && (((m_k - RD) % RR) == 0);
                sv  = (hv & ~m_pheld) | (rep ? hv : 4'b0000);
                nx = m_x; ny = m_y;
                if (in_aim && !pe) begin
                    dx = ((sv[0] && !key_left) ? 1 : 0) - ((sv[1] && !key_right) ? 1 : 0);
                    dy = ((sv[2] && !key_up) ? 1 : 0) - ((sv[3] && !key_down) ? 1 : 0);
                    nx = mv(m_x, dx, NR, XMAX - NR);
                    ny = mv(m_y, dy, NR, YMAX - NR);
                end
                rj = SETUP_PHASE && (m_mode == M_CHECK) && (m_age >= LAT) && blocked;
                nmode = m_mode;
                if (!SETUP_PHASE) nmode = M_IDLE;
                else begin
                    case (m_mode)
                        M_IDLE:   nmode = M_AIM;
                        M_AIM:    if (pe) nmode = M_CHECK;
                        M_CHECK:  if (m_age >= LAT) nmode = blocked ? M_AIM : M_COMMIT;
                        M_COMMIT: nmode = M_DONE;
                        M_DONE:   if (pe) nmode = M_AIM;
                        default:  nmode = M_IDLE;
                    endcase
                    if (m_mode == M_COMMIT) m_placed = 1;
                    else if (m_mode == M_IDLE || (m_mode == M_DONE && pe)) m_placed = 0;
                end
                if (nx != m_x || ny != m_y) m_age = 0;
                else if (m_age < LAT) m_age++;
                m_x = nx; m_y = ny; m_rej = rj; m_mode = nmode;
                m_was_aim = in_aim; m_pheld = hv; m_pplace = key_place;
            end
        end
    end

    // Every-cycle comparison against the model, after inputs have settled.
    initial begin : compare
        forever begin
            @(negedge setup_clk);
            #1;
            if (RESET) begin
                chk("rst_x", int'(cursor_x), XMAX / 2);
                chk("rst_y", int'(cursor_y), YMAX / 2);
                chk("rst_set", int'(SET), 0);
                chk("rst_placed", int'(placed), 0);
                chk("rst_reject", int'(reject), 0);
            end else begin
                chk("cursor_x", int'(cursor_x), m_x);
                chk("cursor_y", int'(cursor_y), m_y);
                chk("SET", int'(SET), (m_mode == M_COMMIT && SETUP_PHASE) ? 1 : 0);
                chk("placed", int'(placed), int'(m_placed));
                chk("reject", int'(reject), int'(m_rej));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge setup_clk);
    endtask

    task automatic set_key(input int which, input logic v);
        case (which)
            KU: key_up = v;
            KD: key_down = v;
            KL: key_left = v;
            KR: key_right = v;
            default: key_place = v;
        endcase
    endtask

    // Key high across exactly n rising clocks.
    task automatic hold(input int which, input int n);
        @(negedge setup_clk);
        set_key(which, 1'b1);
        repeat (n) @(negedge setup_clk);
        set_key(which, 1'b0);
    endtask

    initial begin : drive
        int rc, sc, sx, sy;
        cyc(2);
        #2;
        chk("lit_rst_x", int'(cursor_x), 319);
        chk("lit_rst_y", int'(cursor_y), 239);
        chk("lit_rst_set", int'(SET), 0);
        chk("lit_rst_placed", int'(placed), 0);
        @(negedge setup_clk);
        RESET = 1'b0;
        SETUP_PHASE = 1'b1;

        for (int i = 0; i < 3; i++) begin hold(KR, 1); cyc(1); end
        #2;
        chk("lit_taps_x", int'(cursor_x), 322);
        chk("lit_taps_y", int'(cursor_y), 239);

        // blocked placement
        blocked = 1'b1;
        hold(KP, 1);
        rc = 0; sc = 0;
        repeat (8) begin
            #2;
            if (reject) rc++;
            if (SET) sc++;
            @(negedge setup_clk);
        end
        chk("lit_reject_pulses", rc, 1);
        chk("lit_blocked_no_set", sc, 0);

        // clear placement
        blocked = 1'b0;
        hold(KP, 1);
        rc = 0; sc = 0; sx = -1; sy = -1;
        repeat (8) begin
            #2;
            if (reject) rc++;
            if (SET) begin sc++; sx = int'(cursor_x); sy = int'(cursor_y); end
            @(negedge setup_clk);
        end
        chk("lit_set_cycles", sc, 1);
        chk("lit_set_x", sx, 322);
        chk("lit_set_y", sy, 239);
        chk("lit_clear_no_reject", rc, 0);
        #2;
        chk("lit_placed", int'(placed), 1);

        // re-place from DONE
        hold(KP, 1);
        cyc(1);
        #2;
        chk("lit_replace_placed", int'(placed), 0);

        // auto-repeat
        for (int i = 0; i < 3; i++) begin hold(KL, 1); cyc(1); end
        hold(KL, 36);
        cyc(1);
        #2;
        chk("lit_repeat_x", int'(cursor_x), 313);

        // clamp at the top edge
        hold(KU, 1200);
        cyc(1);
`ifndef NEST_PLACER_WRAP_EN
        #2;
        chk("lit_clamp_y", int'(cursor_y), 8);
`endif

        // steer to (400,100): 87 right steps, 92 down steps
        hold(KR, RD + RR * 85 + 1);
        hold(KD, RD + RR * 90 + 1);
        cyc(1);
        #2;
        chk("lit_steer_x", int'(cursor_x), 400);
`ifndef NEST_PLACER_WRAP_EN
        chk("lit_steer_y", int'(cursor_y), 100);
`endif

        // reset mid-AIM
        @(negedge setup_clk);
        RESET = 1'b1;
        #2;
        chk("lit_midrst_x", int'(cursor_x), 319);
        chk("lit_midrst_y", int'(cursor_y), 239);
        chk("lit_midrst_set", int'(SET), 0);
        @(negedge setup_clk);
        RESET = 1'b0;
        cyc(2);

        // abort a commit by dropping SETUP_PHASE
        hold(KP, 1);
        @(negedge setup_clk);
        SETUP_PHASE = 1'b0;
        #2;
        chk("lit_abort_set", int'(SET), 0);
        hold(KR, 30);
        cyc(1);
        #2;
        chk("lit_idle_x", int'(cursor_x), 319);
        chk("lit_idle_placed", int'(placed), 0);

        // randomized traffic
        @(negedge setup_clk);
        SETUP_PHASE = 1'b1;
        repeat (3000) begin
            @(negedge setup_clk);
            if ($urandom_range(0, 7) == 0) key_up = ~key_up;
            if ($urandom_range(0, 7) == 0) key_down = ~key_down;
            if ($urandom_range(0, 7) == 0) key_left = ~key_left;
            if ($urandom_range(0, 7) == 0) key_right = ~key_right;
            if ($urandom_range(0, 11) == 0) key_place = ~key_place;
            blocked = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 149) == 0) SETUP_PHASE = ~SETUP_PHASE;
            if (RESET) RESET = 1'b0;
            else if ($urandom_range(0, 599) == 0) RESET = 1'b1;
        end
        @(negedge setup_clk);
        RESET = 1'b0;
        cyc(2);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
